// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared constants, FSM state type and index helper for the FIFO write arbiter
package fifo_arb_pkg;
   localparam int FIFO_DEPTH = 64;
   localparam int DATA_W     = 8;
   localparam int CNT_W      = 8;

   typedef enum logic {
      ARB  = 1'b0,
      LOCK = 1'b1
   } arb_state_t;

   function automatic int next_idx(input int idx, input int n);
      return (idx == n - 1) ? 0 : idx + 1;
   endfunction
endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick: rotate from ptr, first active request wins
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   input  logic          en,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx
);
   import fifo_arb_pkg::*;

   always_comb begin
      logic [IW-1:0] cand;
      logic          found;
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      cand  = '0;
      for (int k = 0; k < N; k++) begin
         cand = IW'((int'(ptr) + k) % N);
         if (en && !found && req[cand]) begin
            gnt[cand] = 1'b1;
            idx       = cand;
            found     = 1'b1;
         end
      end
   end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin arbiter sharing the FIFO write port among NUM_REQ requesters
// Optional packet lock enabled by defining FIFO_ARB_LOCK_EN.
module fifo_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_W     = fifo_arb_pkg::DATA_W,
   parameter int FIFO_DEPTH = fifo_arb_pkg::FIFO_DEPTH,
   localparam int IW        = $clog2(NUM_REQ)
) (
   input  logic                            wr_clk,
   input  logic                            rst,
   input  logic [NUM_REQ-1:0]              req,
   input  logic [NUM_REQ*DATA_W-1:0]       req_data,
   input  logic [NUM_REQ-1:0]              req_last,
   output logic [NUM_REQ-1:0]              gnt,
   input  logic [fifo_arb_pkg::CNT_W-1:0]  fifo_counter,
   output logic                            fifo_wr_en,
   output logic [DATA_W-1:0]               fifo_buf_in,
   output logic [IW-1:0]                   grant_id,
   output logic                            locked
);
   import fifo_arb_pkg::*;

   logic [IW-1:0]      ptr;
   logic [IW-1:0]      win;
   logic [IW-1:0]      win_next;
   logic [NUM_REQ-1:0] req_eff;
   logic               space_ok;
   logic               accept;

   // The registered write is not yet in fifo_counter, so count it as occupied.
   assign space_ok = ({1'b0, fifo_counter} + {{CNT_W{1'b0}}, fifo_wr_en}) < 9'(FIFO_DEPTH);
   assign accept   = |gnt;
   assign win_next = IW'(next_idx(int'(win), NUM_REQ));

   rr_pick #(
      .N  (NUM_REQ),
      .IW (IW)
   ) u_pick (
      .req (req_eff),
      .ptr (ptr),
      .en  (space_ok && !rst),
      .gnt (gnt),
      .idx (win)
   );

`ifdef FIFO_ARB_LOCK_EN
   arb_state_t    state;
   logic [IW-1:0] owner;

   assign req_eff = (state == LOCK) ? (req & (NUM_REQ'(1) << owner)) : req;

   always_ff @(posedge wr_clk) begin
      if (rst) begin
         state  <= ARB;
         owner  <= '0;
         ptr    <= '0;
         locked <= 1'b0;
      end else begin
         case (state)
            ARB: begin
               if (accept) begin
                  if (req_last[win]) begin
                     ptr <= win_next;
                  end else begin
                     state  <= LOCK;
                     owner  <= win;
                     locked <= 1'b1;
                  end
               end
            end
            LOCK: begin
               // ptr stays frozen for the whole packet and resumes after the owner.
               if (accept && req_last[win]) begin
                  state  <= ARB;
                  ptr    <= IW'(next_idx(int'(owner), NUM_REQ));
                  locked <= 1'b0;
               end
            end
            default: begin
               state  <= ARB;
               locked <= 1'b0;
            end
         endcase
      end
   end
`else
   logic unused_last;

   assign unused_last = ^req_last;
   assign req_eff     = req;
   assign locked      = 1'b0;

   always_ff @(posedge wr_clk) begin
      if (rst) begin
         ptr <= '0;
      end else if (accept) begin
         ptr <= win_next;
      end
   end
`endif

   always_ff @(posedge wr_clk) begin
      if (rst) begin
         fifo_wr_en  <= 1'b0;
         fifo_buf_in <= '0;
         grant_id    <= '0;
      end else begin
         fifo_wr_en <= accept;
         if (accept) begin
            fifo_buf_in <= req_data[int'(win)*DATA_W +: DATA_W];
            grant_id    <= win;
         end
      end
   end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - table-driven scoreboard bench for fifo_wr_arbiter (both FIFO_ARB_LOCK_EN builds)
module tb_fifo_wr_arbiter;

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic [3:0] last;
      logic [7:0] cnt;
      logic [3:0] exp_gnt;
      logic       exp_lk;
   } vec_t;

   typedef struct {
      logic [1:0] id;
      logic [7:0] data;
   } beat_t;

   logic        wr_clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic [3:0]  req_last;
   logic [3:0]  gnt;
   logic [7:0]  fifo_counter;
   logic        fifo_wr_en;
   logic [7:0]  fifo_buf_in;
   logic [1:0]  grant_id;
   logic        locked;

   logic        rst3;
   logic [2:0]  req3;
   logic [23:0] req_data3;
   logic [2:0]  req_last3;
   logic [2:0]  gnt3;
   logic [7:0]  fifo_counter3;
   logic        fifo_wr_en3;
   logic [7:0]  fifo_buf_in3;
   logic [1:0]  grant_id3;
   logic        locked3;

   vec_t  vecs[$];
   beat_t sb[$];
   int    checks   = 0;
   int    failures = 0;
   int    beats[4] = '{0, 0, 0, 0};
   logic [3:0] prev_gnt = 4'b0;

   always #5 wr_clk = ~wr_clk;

   fifo_wr_arbiter #(.NUM_REQ(4), .DATA_W(8), .FIFO_DEPTH(64)) dut (
      .wr_clk       (wr_clk),
      .rst          (rst),
      .req          (req),
      .req_data     (req_data),
      .req_last     (req_last),
      .gnt          (gnt),
      .fifo_counter (fifo_counter),
      .fifo_wr_en   (fifo_wr_en),
      .fifo_buf_in  (fifo_buf_in),
      .grant_id     (grant_id),
      .locked       (locked)
   );

   fifo_wr_arbiter #(.NUM_REQ(3), .DATA_W(8), .FIFO_DEPTH(64)) dut3 (
      .wr_clk       (wr_clk),
      .rst          (rst3),
      .req          (req3),
      .req_data     (req_data3),
      .req_last     (req_last3),
      .gnt          (gnt3),
      .fifo_counter (fifo_counter3),
      .fifo_wr_en   (fifo_wr_en3),
      .fifo_buf_in  (fifo_buf_in3),
      .grant_id     (grant_id3),
      .locked       (locked3)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic r, input logic [3:0] q, input logic [3:0] l,
                               input logic [7:0] c, input logic [3:0] g, input logic k);
      vec_t v;
      v.rst = r; v.req = q; v.last = l; v.cnt = c; v.exp_gnt = g; v.exp_lk = k;
      return v;
   endfunction

   task automatic apply(input vec_t v, input int row);
      beat_t b;
      rst          = v.rst;
      req          = v.req;
      req_last     = v.last;
      fifo_counter = v.cnt;
      for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = 8'(i*32 + beats[i]);
      @(negedge wr_clk);
      check($sformatf("gnt row%0d", row), 32'(gnt), 32'(v.exp_gnt));
      check($sformatf("locked row%0d", row), 32'(locked), 32'(v.exp_lk));
      check($sformatf("wr_en row%0d", row), 32'(fifo_wr_en), 32'(|prev_gnt));
      if (|prev_gnt) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard row%0d actual=empty required=beat", row);
         end else begin
            b = sb.pop_front();
            check($sformatf("buf_in row%0d", row), 32'(fifo_buf_in), 32'(b.data));
            check($sformatf("grant_id row%0d", row), 32'(grant_id), 32'(b.id));
         end
      end
      for (int i = 0; i < 4; i++) begin
         if (v.exp_gnt[i]) begin
            b.id   = 2'(i);
            b.data = 8'(i*32 + beats[i]);
            beats[i]++;
            sb.push_back(b);
         end
      end
      prev_gnt = v.exp_gnt;
      @(posedge wr_clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0] exp3[4];
      logic [7:0] dat3[3];
      rst = 1'b1; req = '0; req_last = '0; req_data = '0; fifo_counter = '0;
      rst3 = 1'b1; req3 = '0; req_last3 = 3'b111; req_data3 = 24'hCC_BB_AA; fifo_counter3 = '0;
      exp3 = '{3'b001, 3'b100, 3'b001, 3'b100};
      dat3 = '{8'hAA, 8'hBB, 8'hCC};
      @(posedge wr_clk);
      #1;

      apply(mk(1, 4'h0, 4'h0, 8'd0, 4'h0, 0), 0);
      apply(mk(1, 4'h0, 4'h0, 8'd0, 4'h0, 0), 1);
      check("reset buf_in", 32'(fifo_buf_in), 32'h0);
      check("reset grant_id", 32'(grant_id), 32'h0);
      check("reset wr_en", 32'(fifo_wr_en), 32'h0);

      // free arbitration
      vecs.push_back(mk(0, 4'hF, 4'hF, 8'd0, 4'h1, 0));
      vecs.push_back(mk(0, 4'hF, 4'hF, 8'd0, 4'h2, 0));
      vecs.push_back(mk(0, 4'hF, 4'hF, 8'd0, 4'h4, 0));
      vecs.push_back(mk(0, 4'hF, 4'hF, 8'd0, 4'h8, 0));
      vecs.push_back(mk(0, 4'hF, 4'hF, 8'd0, 4'h1, 0));
      vecs.push_back(mk(0, 4'h0, 4'h0, 8'd0, 4'h0, 0));
      // full boundary, FIFO counter lagging the registered write by one edge
      vecs.push_back(mk(0, 4'h1, 4'h1, 8'd62, 4'h1, 0));
      vecs.push_back(mk(0, 4'h1, 4'h1, 8'd62, 4'h1, 0));
      vecs.push_back(mk(0, 4'h1, 4'h1, 8'd63, 4'h0, 0));
      vecs.push_back(mk(0, 4'h1, 4'h1, 8'd64, 4'h0, 0));
      vecs.push_back(mk(0, 4'h1, 4'h1, 8'd63, 4'h1, 0));
      vecs.push_back(mk(0, 4'h1, 4'h1, 8'd63, 4'h0, 0));
      vecs.push_back(mk(0, 4'h1, 4'h1, 8'd64, 4'h0, 0));
      vecs.push_back(mk(0, 4'h0, 4'h0, 8'd0, 4'h0, 0));
      vecs.push_back(mk(1, 4'h0, 4'h0, 8'd0, 4'h0, 0));
`ifdef FIFO_ARB_LOCK_EN
      // 3-beat packet from req0 with req1 waiting
      vecs.push_back(mk(0, 4'h3, 4'h0, 8'd0, 4'h1, 0));
      vecs.push_back(mk(0, 4'h3, 4'h0, 8'd0, 4'h1, 1));
      vecs.push_back(mk(0, 4'h3, 4'h3, 8'd0, 4'h1, 1));
      vecs.push_back(mk(0, 4'h2, 4'h2, 8'd0, 4'h2, 0));
      vecs.push_back(mk(0, 4'h0, 4'h0, 8'd0, 4'h0, 0));
      // reset while requester 2 owns the lock
      vecs.push_back(mk(1, 4'h0, 4'h0, 8'd0, 4'h0, 0));
      vecs.push_back(mk(0, 4'h4, 4'h0, 8'd0, 4'h4, 0));
      vecs.push_back(mk(0, 4'h5, 4'h0, 8'd0, 4'h4, 1));
      vecs.push_back(mk(1, 4'h5, 4'h0, 8'd0, 4'h0, 1));
      vecs.push_back(mk(0, 4'h5, 4'h5, 8'd0, 4'h1, 0));
      vecs.push_back(mk(0, 4'h5, 4'h5, 8'd0, 4'h4, 0));
      vecs.push_back(mk(0, 4'h0, 4'h0, 8'd0, 4'h0, 0));
`else
      vecs.push_back(mk(0, 4'h3, 4'h0, 8'd0, 4'h1, 0));
      vecs.push_back(mk(0, 4'h3, 4'h0, 8'd0, 4'h2, 0));
      vecs.push_back(mk(0, 4'h3, 4'h0, 8'd0, 4'h1, 0));
      vecs.push_back(mk(0, 4'h3, 4'h0, 8'd0, 4'h2, 0));
      vecs.push_back(mk(0, 4'h3, 4'h1, 8'd0, 4'h1, 0));
      vecs.push_back(mk(0, 4'h2, 4'h2, 8'd0, 4'h2, 0));
      vecs.push_back(mk(0, 4'h0, 4'h0, 8'd0, 4'h0, 0));
      vecs.push_back(mk(1, 4'h0, 4'h0, 8'd0, 4'h0, 0));
      vecs.push_back(mk(0, 4'h4, 4'h0, 8'd0, 4'h4, 0));
      vecs.push_back(mk(0, 4'h5, 4'h0, 8'd0, 4'h1, 0));
      vecs.push_back(mk(1, 4'h5, 4'h0, 8'd0, 4'h0, 0));
      vecs.push_back(mk(0, 4'h5, 4'h5, 8'd0, 4'h1, 0));
      vecs.push_back(mk(0, 4'h5, 4'h5, 8'd0, 4'h4, 0));
      vecs.push_back(mk(0, 4'h0, 4'h0, 8'd0, 4'h0, 0));
`endif
      for (int r = 0; r < vecs.size(); r++) apply(vecs[r], r + 2);
      check("scoreboard drained", 32'(sb.size()), 32'd0);

      // three requesters: pointer wraps from 2 back to 0
      rst3 = 1'b0;
      req3 = 3'b101;
      for (int k = 0; k < 4; k++) begin
         @(negedge wr_clk);
         check($sformatf("gnt3 step%0d", k), 32'(gnt3), 32'(exp3[k]));
         if (k > 0) begin
            check($sformatf("wr_en3 step%0d", k), 32'(fifo_wr_en3), 32'd1);
            check($sformatf("grant_id3 step%0d", k), 32'(grant_id3), (exp3[k-1] == 3'b001) ? 32'd0 : 32'd2);
            check($sformatf("buf_in3 step%0d", k), 32'(fifo_buf_in3),
                  32'((exp3[k-1] == 3'b001) ? dat3[0] : dat3[2]));
         end
         @(posedge wr_clk);
         #1;
      end
      req3 = 3'b000;
      @(negedge wr_clk);
      check("grant_id3 final", 32'(grant_id3), 32'd2);
      check("locked3", 32'(locked3), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
